// File: rtl/tablero_pkg.sv
// Shared definitions for the board reader: FSM states, cell codes and board geometry.
package tablero_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    EMITE  = 2'd1,
    FIN    = 2'd2
  } estado_t;

  localparam logic [1:0] VACIA    = 2'b00;
  localparam logic [1:0] X        = 2'b01;
  localparam logic [1:0] O        = 2'b10;
  localparam logic [1:0] INVALIDA = 2'b11;

  localparam int         NUM_CELDAS = 9;
  localparam logic [3:0] ULTIMA     = 4'(NUM_CELDAS - 1);

endpackage

// File: rtl/lector_tablero.sv
// Snapshots a 3x3 board and presents its cells one by one on a valid/ready
// handshake, tallying X, O and invalid codes as they are consumed.
module lector_tablero
  import tablero_pkg::*;
#(
  parameter bit SALTAR_VACIAS = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicio,
  input  logic [5:0] fila0,
  input  logic [5:0] fila1,
  input  logic [5:0] fila2,
  output logic [1:0] celda_dato,
  output logic [3:0] celda_indice,
  output logic       celda_valida,
  input  logic       celda_lista,
  output logic       ocupado,
  output logic       fin,
  output logic [3:0] cuenta_x,
  output logic [3:0] cuenta_o,
  output logic       error
);

  estado_t     estado, estado_sig;
  logic [17:0] snapshot;
  logic [3:0]  indice;
  logic        listo;
  logic [1:0]  celda_actual;
  logic        acepta;
  logic        avanza;
  logic        transfer;

  assign celda_actual = snapshot[{indice, 1'b0} +: 2];

  // listo stays low for the first edge after reset so inicio is honoured from the second edge on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) listo <= 1'b0;
    else        listo <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  // celda_valida depends only on state and snapshot, never on celda_lista.
  always_comb begin
    estado_sig   = estado;
    celda_valida = 1'b0;
    acepta       = 1'b0;
    avanza       = 1'b0;
    case (estado)
      REPOSO: begin
        acepta = inicio && listo;
        if (acepta) estado_sig = EMITE;
      end
      EMITE: begin
        celda_valida = !SALTAR_VACIAS || (celda_actual != VACIA);
        avanza       = celda_valida ? celda_lista : 1'b1;
        if (avanza && (indice == ULTIMA)) estado_sig = FIN;
      end
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  assign transfer = celda_valida && celda_lista;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot <= '0;
      indice   <= '0;
      cuenta_x <= '0;
      cuenta_o <= '0;
      error    <= 1'b0;
    end else if (acepta) begin
      snapshot <= {fila2, fila1, fila0};
      indice   <= '0;
      cuenta_x <= '0;
      cuenta_o <= '0;
      error    <= 1'b0;
    end else begin
      if (transfer) begin
        if (celda_actual == X)        cuenta_x <= cuenta_x + 4'd1;
        if (celda_actual == O)        cuenta_o <= cuenta_o + 4'd1;
        if (celda_actual == INVALIDA) error    <= 1'b1;
      end
      if (avanza && (indice != ULTIMA)) indice <= indice + 4'd1;
    end
  end

  assign celda_dato   = (estado == EMITE) ? celda_actual : VACIA;
  assign celda_indice = indice;
  assign ocupado      = (estado != REPOSO);
  assign fin          = (estado == FIN);

endmodule

// File: tb/tb_lector_tablero.sv
// Self-checking bench: runs a skip-empty and a present-all reader side by side
// against a cell-list reference model, plus literal expectations for known boards.
module tb_lector_tablero;
  import tablero_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inicio = 1'b0;
  logic       lista = 1'b0;
  logic [5:0] fila0 = '0, fila1 = '0, fila2 = '0;

  logic [1:0] dato_o [2];
  logic [3:0] idx_o  [2];
  logic       val_o  [2];
  logic       ocu_o  [2];
  logic       fin_o  [2];
  logic       err_o  [2];
  logic [3:0] cx_o   [2];
  logic [3:0] co_o   [2];

  always #5 clk = ~clk;

  lector_tablero #(.SALTAR_VACIAS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio),
    .fila0(fila0), .fila1(fila1), .fila2(fila2),
    .celda_dato(dato_o[0]), .celda_indice(idx_o[0]), .celda_valida(val_o[0]),
    .celda_lista(lista), .ocupado(ocu_o[0]), .fin(fin_o[0]),
    .cuenta_x(cx_o[0]), .cuenta_o(co_o[0]), .error(err_o[0])
  );

  lector_tablero #(.SALTAR_VACIAS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio),
    .fila0(fila0), .fila1(fila1), .fila2(fila2),
    .celda_dato(dato_o[1]), .celda_indice(idx_o[1]), .celda_valida(val_o[1]),
    .celda_lista(lista), .ocupado(ocu_o[1]), .fin(fin_o[1]),
    .cuenta_x(cx_o[1]), .cuenta_o(co_o[1]), .error(err_o[1])
  );

  // Reference model: a list of 9 captured cells and a cursor into it, per instance.
  bit         m_busy [2];
  bit         m_fin  [2];
  int         m_pos  [2];
  logic [1:0] m_cells[2][9];
  int         m_cx   [2];
  int         m_co   [2];
  bit         m_err  [2];
  int         m_xfer [2];
  int         fin_seen[2];
  int         edges_since_reset;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input int k, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("[TB] FAIL %s (dut%0d): got %0d, expected %0d at %0t", name, k, act, exp_v, $time);
    end
  endtask

  function automatic bit m_valid(input int k);
    return m_busy[k] && ((k == 0) || (m_cells[k][m_pos[k]] != VACIA));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_fin[k] = 0; m_pos[k] = 0;
      m_cx[k] = 0; m_co[k] = 0; m_err[k] = 0;
      for (int c = 0; c < 9; c++) m_cells[k][c] = VACIA;
    end
    edges_since_reset = 0;
  endtask

  task automatic model_step();
    logic [17:0] b;
    bit v, adv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    b = {fila2, fila1, fila0};
    for (int k = 0; k < 2; k++) begin
      if (m_fin[k]) begin
        m_fin[k] = 0;
      end else if (m_busy[k]) begin
        v   = m_valid(k);
        adv = v ? lista : 1'b1;
        if (v && lista) begin
          m_xfer[k]++;
          case (m_cells[k][m_pos[k]])
            X:        m_cx[k]++;
            O:        m_co[k]++;
            INVALIDA: m_err[k] = 1;
            default:  ;
          endcase
        end
        if (adv) begin
          if (m_pos[k] == 8) begin m_busy[k] = 0; m_fin[k] = 1; end
          else m_pos[k]++;
        end
      end else if (inicio && edges_since_reset >= 1) begin
        for (int c = 0; c < 9; c++) m_cells[k][c] = b[2*c +: 2];
        m_pos[k] = 0; m_busy[k] = 1;
        m_cx[k] = 0; m_co[k] = 0; m_err[k] = 0;
      end
    end
    edges_since_reset++;
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check("ocupado", k, ocu_o[k], int'(m_busy[k] || m_fin[k]));
      check("fin", k, fin_o[k], int'(m_fin[k]));
      check("celda_valida", k, val_o[k], int'(m_valid(k)));
      if (m_busy[k]) begin
        check("celda_dato", k, dato_o[k], int'(m_cells[k][m_pos[k]]));
        check("celda_indice", k, idx_o[k], m_pos[k]);
      end
      if (!rst_n) begin
        check("dato_en_reset", k, dato_o[k], 0);
        check("indice_en_reset", k, idx_o[k], 0);
      end
      check("cuenta_x", k, cx_o[k], m_cx[k]);
      check("cuenta_o", k, co_o[k], m_co[k]);
      check("error", k, err_o[k], int'(m_err[k]));
      if (fin_o[k]) fin_seen[k]++;
    end
  endtask

  task automatic tick(input logic ini, input logic lis);
    inicio = ini;
    lista  = lis;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 60 && (m_busy[0] || m_fin[0] || m_busy[1] || m_fin[1]); n++)
      tick(1'b0, 1'b1);
  endtask

  // patron 0: lista always 1; patron 1: lista 1,0,0,1 repeating. Returns tick of fin per instance.
  task automatic scan(input logic [5:0] f0, input logic [5:0] f1, input logic [5:0] f2,
                      input int patron, input bit revolver, output int fa0, output int fa1);
    logic lis;
    wait_idle();
    fila0 = f0; fila1 = f1; fila2 = f2;
    m_xfer[0] = 0; m_xfer[1] = 0;
    fin_seen[0] = 0; fin_seen[1] = 0;
    tick(1'b1, 1'b1);
    fa0 = -1; fa1 = -1;
    for (int n = 1; n <= 60; n++) begin
      lis = (patron == 0) ? 1'b1 : (((n - 1) % 4 == 0) || ((n - 1) % 4 == 3));
      if (revolver) begin
        fila0 = 6'($urandom); fila1 = 6'($urandom); fila2 = 6'($urandom);
      end
      tick(1'b0, lis);
      if (fin_o[0] && fa0 < 0) fa0 = n;
      if (fin_o[1] && fa1 < 0) fa1 = n;
      if (fa0 >= 0 && fa1 >= 0) break;
    end
  endtask

  initial begin
    int fa0, fa1;
    model_reset();
    m_xfer[0] = 0; m_xfer[1] = 0; fin_seen[0] = 0; fin_seen[1] = 0;
    #2;
    check_outputs();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    rst_n = 1'b1;
    // First edge after reset release must not start a scan.
    tick(1'b1, 1'b1);
    check("arranque_temprano", 0, ocu_o[0], 0);
    tick(1'b0, 1'b1);

    // Empty board: fin in the 10th period after the accepting edge.
    scan(6'b000000, 6'b000000, 6'b000000, 0, 1'b0, fa0, fa1);
    check("vacio_fin_lat", 0, fa0, 9);
    check("vacio_fin_lat", 1, fa1, 9);
    check("vacio_transfers", 0, m_xfer[0], 9);
    check("vacio_transfers", 1, m_xfer[1], 0);
    check("vacio_cx", 0, cx_o[0], 0);
    check("vacio_co", 0, co_o[0], 0);

    scan(6'b011001, 6'b100100, 6'b000110, 0, 1'b0, fa0, fa1);
    check("tablero_cx", 0, cx_o[0], 4);
    check("tablero_co", 0, co_o[0], 3);
    check("tablero_err", 0, err_o[0], 0);
    check("tablero_transfers", 0, m_xfer[0], 9);
    check("tablero_transfers", 1, m_xfer[1], 7);
    check("tablero_fin_lat", 1, fa1, 9);

    scan(6'b011001, 6'b100100, 6'b000110, 1, 1'b1, fa0, fa1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("lista_alterna_transfers", 0, m_xfer[0], 9);
    check("lista_alterna_fin_unico", 0, fin_seen[0], 1);
    check("lista_alterna_fin_unico", 1, fin_seen[1], 1);
    check("lista_alterna_cx", 0, cx_o[0], 4);
    check("lista_alterna_co", 1, co_o[1], 3);

    scan(6'b000000, 6'b110000, 6'b000000, 0, 1'b0, fa0, fa1);
    check("invalida_err", 0, err_o[0], 1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    check("invalida_err_retenido", 0, err_o[0], 1);
    fila1 = 6'b000000;
    tick(1'b1, 1'b1);
    check("invalida_err_borrado", 0, err_o[0], 0);
    wait_idle();

    // Asynchronous reset in the middle of a scan.
    fila0 = 6'b011001; fila1 = 6'b100100; fila2 = 6'b000110;
    tick(1'b1, 1'b1);
    for (int n = 0; n < 20 && m_pos[0] != 4; n++) tick(1'b0, 1'b1);
    check("pre_reset_indice", 0, idx_o[0], 4);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("reset_async_ocupado", 0, ocu_o[0], 0);
    check("reset_async_indice", 0, idx_o[0], 0);
    tick(1'b0, 1'b1);
    rst_n = 1'b1;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check("reinicio_indice", 0, idx_o[0], 0);
    check("reinicio_valida", 0, val_o[0], 1);

    // Random traffic with rows scrambled every cycle and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      fila0 = 6'($urandom); fila1 = 6'($urandom); fila2 = 6'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
      end
      tick(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lector_tablero.md
LECTOR_TABLERO -- requirements
Module: lector_tablero

Interface
REQ-001 Parameter SALTAR_VACIAS, default 0, meaning: 1 = empty cells are skipped and never presented on the output handshake.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 inicio  input  1  start request; sampled only in REPOSO.
REQ-005 fila0, fila1, fila2  input  6 each  board rows; cell c of row r is bits [2c+1:2c] and has board index 3r+c.
REQ-006 celda_dato  output  2  code of presented cell: 00 empty, 01 X, 10 O, 11 invalid.
REQ-007 celda_indice  output  4  board index 0..8 of presented cell.
REQ-008 celda_valida  output  1  presented cell is valid.
REQ-009 celda_lista  input  1  consumer accepts; transfer occurs when celda_valida and celda_lista are both 1 on a rising edge.
REQ-010 ocupado  output  1  scan in progress.
REQ-011 fin  output  1  one-cycle pulse at scan completion.
REQ-012 cuenta_x, cuenta_o  output  4 each  number of X / O cells transferred in the current or last scan.
REQ-013 error  output  1  at least one 11 code transferred in the current or last scan.

Function
REQ-014 The FSM SHALL have exactly three states: REPOSO, EMITE and FIN.
REQ-015 In REPOSO with inicio=1, the block SHALL snapshot {fila2,fila1,fila0} into an 18-bit register, set indice=0, clear cuenta_x, cuenta_o and error, and enter EMITE on the same edge.
REQ-016 Once captured, the scan SHALL use only the snapshot; row input changes during a scan SHALL have no effect.
REQ-017 In EMITE, celda_dato SHALL equal snapshot bits [2*indice+1 : 2*indice] and celda_indice SHALL equal indice.
REQ-018 With SALTAR_VACIAS=0, in EMITE celda_valida SHALL be 1 for every cell.
REQ-019 celda_dato and celda_indice SHALL remain stable while celda_valida=1 and celda_lista=0; there is no timeout.
REQ-020 On a transfer, cuenta_x SHALL increment on code 01, cuenta_o SHALL increment on code 10, and error SHALL be set on code 11; error SHALL be sticky until the next accepted inicio.
REQ-021 On a transfer with indice<8, indice SHALL increment; on a transfer with indice=8, the FSM SHALL enter FIN.
REQ-022 With SALTAR_VACIAS=1, an empty current cell SHALL hold celda_valida=0 and advance indice in one cycle; if indice=8, the FSM SHALL enter FIN.
REQ-023 In FIN, fin=1 for exactly one cycle, then the FSM SHALL return to REPOSO.
REQ-024 ocupado SHALL be 1 in EMITE and FIN and 0 in REPOSO; inicio SHALL be ignored while ocupado=1.
REQ-025 Latency: celda_valida SHALL rise the cycle after inicio is accepted. With celda_lista held at 1 and SALTAR_VACIAS=0, fin SHALL assert 10 cycles after acceptance.
REQ-026 Outputs SHALL be registered or decoded from state only, with no combinational path from celda_lista to celda_valida.
REQ-027 cuenta_x, cuenta_o and error SHALL hold their final values in REPOSO until the next accepted inicio.
REQ-028 With SALTAR_VACIAS=1 and an all-empty board, the block SHALL emit no transfers and pulse fin 10 cycles after acceptance.

Reset
REQ-029 rst_n=0 SHALL immediately force REPOSO and set snapshot=0, indice=0, celda_valida=0, fin=0, ocupado=0, cuenta_x=0, cuenta_o=0 and error=0, including mid-scan.
REQ-030 After rst_n deasserts, the block SHALL accept inicio no earlier than the second rising edge.

Structure
REQ-031 Shared package tablero_pkg SHALL hold the state enum, the cell code constants (VACIA, X, O, INVALIDA) and NUM_CELDAS=9.
REQ-032 The block is a single module; the cell mux and counters are inline, with no sub-module.

Verification
REQ-033 rows 000000/000000/000000, inicio pulse, lista=1, SALTAR_VACIAS=0 -> 9 transfers at indices 0..8, all dato=00; fin 10 cycles after acceptance; cuenta_x=0, cuenta_o=0.
REQ-034 fila0=011001, fila1=100100, fila2=000110, lista=1 -> dato sequence 01,10,01,00,01,10,10,01,00; cuenta_x=4, cuenta_o=3, error=0.
REQ-035 Same board, lista toggled 1,0,0,1,... -> dato and indice are held during lista=0; the same sequence is produced and fin asserts once.
REQ-036 SALTAR_VACIAS=1, same board -> only 7 transfers at indices 0,1,2,4,5,6,7; fin asserts once.
REQ-037 fila1=110000 -> error=1 after index 5 transfers; error stays 1 in REPOSO and clears on the next inicio.
REQ-038 rst_n pulsed low at indice=4 -> all outputs 0 asynchronously; a new inicio restarts the scan at index 0; rows changed mid-scan do not alter the emitted data.
